insight_trap_trace_buffer: RTL and testbench

//  Parametrised trap-trace recorder for the Insight debug view.
//  - Samples trap events (mcause, mepc) from NUM_HARTS harts and stamps each one with csr_time.
//  - Buffers the records in a DEPTH-entry FIFO for a trace consumer to drain.
//  - Keeps per-hart trap counters and a global drop counter.
//  - Sits beside the per-hart CSR Insight views; the consumer side is valid/ready.

---
 rtl/insight_trap_trace_buffer.sv | 136 +++++++++++++
 tb/tb_insight_trap_trace_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/insight_trap_trace_buffer.sv
// rtl/insight_trap_trace_buffer.sv - round-robin trap-trace recorder with FIFO, lost flag and counters
module insight_trap_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int NUM_HARTS = 2,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16,
    localparam int HART_W   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
    localparam int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_HARTS-1:0]       trap_valid,
    input  logic [NUM_HARTS*XLEN-1:0]  trap_cause,
    input  logic [NUM_HARTS*XLEN-1:0]  trap_epc,
    input  logic [XLEN-1:0]            csr_time,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [HART_W-1:0]          out_hart,
    output logic [XLEN-1:0]            out_cause,
    output logic [XLEN-1:0]            out_epc,
    output logic [XLEN-1:0]            out_time,
    output logic                       out_lost,
    output logic [LVL_W-1:0]           level,
    output logic [CNT_W-1:0]           drop_count,
    output logic [NUM_HARTS*CNT_W-1:0] trap_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int REC_W = HART_W + 3 * XLEN + 1;
    localparam int NV_W  = $clog2(NUM_HARTS + 1);

    logic [REC_W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       count;
    logic [HART_W-1:0]      rr_ptr;
    logic                   lost_pending;

    logic [2*NUM_HARTS-1:0] dbl_valid;
    logic [NUM_HARTS-1:0]   rot_valid;
    logic [HART_W-1:0]      win;
    logic                   any_valid;
    logic [NV_W-1:0]        n_valid;
    logic [NV_W-1:0]        n_drop;
    logic                   pop;
    logic                   push;
    logic [REC_W-1:0]       push_rec;
    logic [REC_W-1:0]       head_rec;
    logic [CNT_W:0]         drop_sum;
    logic [LVL_W-1:0]       next_count;
    logic [PTR_W-1:0]       next_rd;

    // rr_ptr names the hart with highest priority this cycle; rotating puts it at bit 0
    always_comb begin
        dbl_valid = {trap_valid, trap_valid} >> rr_ptr;
        rot_valid = dbl_valid[NUM_HARTS-1:0];
        win       = '0;
        any_valid = 1'b0;
        n_valid   = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (rot_valid[i] && !any_valid) begin
                win       = HART_W'((int'(rr_ptr) + i) % NUM_HARTS);
                any_valid = 1'b1;
            end
            n_valid = n_valid + NV_W'(trap_valid[i]);
        end
    end

    always_comb begin
        pop        = out_valid & out_ready;
        push       = enable & any_valid & ((count < LVL_W'(DEPTH)) | pop);
        n_drop     = enable ? (n_valid - NV_W'(push)) : '0;
        push_rec   = {win,
                      trap_cause[int'(win)*XLEN +: XLEN],
                      trap_epc[int'(win)*XLEN +: XLEN],
                      csr_time,
                      lost_pending | (n_drop != '0)};
        drop_sum   = {1'b0, drop_count} + (CNT_W+1)'(n_drop);
        next_count = count + LVL_W'(push) - LVL_W'(pop);
        next_rd    = rd_ptr + PTR_W'(pop);
        // A record written this cycle into an otherwise empty FIFO becomes the new head directly
        head_rec   = (push && (next_rd == wr_ptr)) ? push_rec : mem[next_rd];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            out_hart     <= '0;
            out_cause    <= '0;
            out_epc      <= '0;
            out_time     <= '0;
            out_lost     <= 1'b0;
            drop_count   <= '0;
            trap_count   <= '0;
            lost_pending <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= HART_W'((int'(win) + 1) % NUM_HARTS);
            end
            rd_ptr    <= next_rd;
            count     <= next_count;
            out_valid <= (next_count != '0);
            if (next_count != '0) begin
                {out_hart, out_cause, out_epc, out_time, out_lost} <= head_rec;
            end
            if (n_drop != '0) begin
                lost_pending <= 1'b1;
                drop_count   <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
            end else if (push) begin
                lost_pending <= 1'b0;
            end
            if (enable) begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (trap_valid[h]) begin
                        trap_count[h*CNT_W +: CNT_W] <= trap_count[h*CNT_W +: CNT_W] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign level = count;

endmodule

// File: tb/tb_insight_trap_trace_buffer.sv
// tb/tb_insight_trap_trace_buffer.sv - queue-model bench for insight_trap_trace_buffer
module tb_insight_trap_trace_buffer;

    localparam int XLEN   = 32;
    localparam int NH     = 2;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam int HART_W = 1;
    localparam int LVL_W  = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [NH-1:0]        trap_valid;
    logic [NH*XLEN-1:0]   trap_cause;
    logic [NH*XLEN-1:0]   trap_epc;
    logic [XLEN-1:0]      csr_time;
    logic                 out_valid;
    logic                 out_ready;
    logic [HART_W-1:0]    out_hart;
    logic [XLEN-1:0]      out_cause;
    logic [XLEN-1:0]      out_epc;
    logic [XLEN-1:0]      out_time;
    logic                 out_lost;
    logic [LVL_W-1:0]     level;
    logic [CNT_W-1:0]     drop_count;
    logic [NH*CNT_W-1:0]  trap_count;

    insight_trap_trace_buffer #(
        .XLEN(XLEN), .NUM_HARTS(NH), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .csr_time(csr_time), .out_valid(out_valid), .out_ready(out_ready),
        .out_hart(out_hart), .out_cause(out_cause), .out_epc(out_epc),
        .out_time(out_time), .out_lost(out_lost), .level(level),
        .drop_count(drop_count), .trap_count(trap_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          hart;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tm;
        bit          lost;
    } rec_t;

    rec_t q[$];
    rec_t m_head;
    rec_t m_rec;
    int   m_drop, m_rr, m_nv, m_win, m_nd;
    int   m_tc [NH];
    bit   m_lost, m_pop, m_push, started = 1'b0;

    // Reference: a queue of records plus plain integer counters
    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            m_drop  = 0;
            m_rr    = 0;
            m_lost  = 1'b0;
            m_head  = '{0, 0, 0, 0, 1'b0};
            for (int k = 0; k < NH; k++) m_tc[k] = 0;
            started = 1'b1;
        end else begin
            m_pop = (q.size() > 0) && out_ready;
            m_nv  = 0;
            m_win = -1;
            if (enable) begin
                for (int k = 0; k < NH; k++) begin
                    if (trap_valid[(m_rr + k) % NH]) begin
                        m_nv++;
                        if (m_win < 0) m_win = (m_rr + k) % NH;
                    end
                    if (trap_valid[k]) m_tc[k] = (m_tc[k] + 1) % (1 << CNT_W);
                end
            end
            m_push = (m_win >= 0) && ((q.size() < DEPTH) || m_pop);
            m_nd   = m_nv - (m_push ? 1 : 0);
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                m_rec.hart  = m_win;
                m_rec.cause = trap_cause[m_win*XLEN +: XLEN];
                m_rec.epc   = trap_epc[m_win*XLEN +: XLEN];
                m_rec.tm    = csr_time;
                m_rec.lost  = m_lost || (m_nd > 0);
                q.push_back(m_rec);
                m_rr = (m_win + 1) % NH;
            end
            m_drop = (m_drop + m_nd > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_drop + m_nd;
            if (m_nd > 0) m_lost = 1'b1;
            else if (m_push) m_lost = 1'b0;
            if (q.size() > 0) m_head = q[0];
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("out_valid", longint'(out_valid), longint'(q.size() > 0));
            chk("level", longint'(level), longint'(q.size()));
            chk("drop_count", longint'(drop_count), longint'(m_drop));
            for (int k = 0; k < NH; k++)
                chk("trap_count", longint'(trap_count[k*CNT_W +: CNT_W]), longint'(m_tc[k]));
            chk("out_hart", longint'(out_hart), longint'(m_head.hart));
            chk("out_cause", longint'(out_cause), longint'(m_head.cause));
            chk("out_epc", longint'(out_epc), longint'(m_head.epc));
            chk("out_time", longint'(out_time), longint'(m_head.tm));
            chk("out_lost", longint'(out_lost), longint'(m_head.lost));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        trap_valid = '0;
        csr_time   = csr_time + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic trap(input int h, input logic [31:0] c, input logic [31:0] e);
        trap_valid[h]                = 1'b1;
        trap_cause[h*XLEN +: XLEN]   = c;
        trap_epc[h*XLEN +: XLEN]     = e;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        out_ready  = 1'b0;
        trap_valid = '0;
        trap_cause = '0;
        trap_epc   = '0;
        csr_time   = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_level", longint'(level), 0);
        chk("rst_drop", longint'(drop_count), 0);
        chk("rst_tc", longint'(trap_count), 0);
        chk("rst_cause", longint'(out_cause), 0);

        // single trap
        csr_time = 32'd42;
        trap(0, 32'hB, 32'h8000_0100);
        step();
        chk("t1_valid", longint'(out_valid), 1);
        chk("t1_hart", longint'(out_hart), 0);
        chk("t1_cause", longint'(out_cause), 'hB);
        chk("t1_epc", longint'(out_epc), 'h8000_0100);
        chk("t1_time", longint'(out_time), 42);
        chk("t1_lost", longint'(out_lost), 0);
        chk("t1_level", longint'(level), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_empty", longint'(out_valid), 0);
        chk("t1_hold", longint'(out_cause), 'hB);

        // two harts at once for two cycles
        do_reset();
        trap(0, 32'h10, 32'h100); trap(1, 32'h11, 32'h200);
        step();
        trap(0, 32'h20, 32'h300); trap(1, 32'h21, 32'h400);
        step();
        chk("t2_level", longint'(level), 2);
        chk("t2_drop", longint'(drop_count), 2);
        chk("t2_tc", longint'(trap_count), 'h22);
        chk("t2_hart0", longint'(out_hart), 0);
        chk("t2_cause0", longint'(out_cause), 'h10);
        chk("t2_lost0", longint'(out_lost), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_hart1", longint'(out_hart), 1);
        chk("t2_cause1", longint'(out_cause), 'h21);
        chk("t2_lost1", longint'(out_lost), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // fill to full, ninth trap dropped
        do_reset();
        for (int i = 0; i < 9; i++) begin
            trap(1, 32'(i + 1), 32'h1000 + 32'(i));
            step();
        end
        chk("t3_level", longint'(level), 8);
        chk("t3_drop", longint'(drop_count), 1);
        chk("t3_tc", longint'(trap_count), 'h90);
        chk("t3_head", longint'(out_cause), 1);

        // push while full with a simultaneous pop
        out_ready = 1'b1;
        trap(1, 32'h99, 32'h2000);
        step();
        chk("t4_level", longint'(level), 8);
        chk("t4_drop", longint'(drop_count), 1);
        chk("t4_head", longint'(out_cause), 2);
        for (int i = 0; i < 7; i++) step();
        chk("t4_new_cause", longint'(out_cause), 'h99);
        chk("t4_new_lost", longint'(out_lost), 1);
        chk("t4_new_level", longint'(level), 1);
        step();
        out_ready = 1'b0;
        chk("t4_drained", longint'(level), 0);

        // drop saturation and trap_count wrap
        do_reset();
        for (int i = 0; i < 28; i++) begin
            trap(1, 32'h500 + 32'(i), 32'h600);
            step();
        end
        chk("t5_drop_sat", longint'(drop_count), 15);
        chk("t5_tc1", longint'(trap_count[7:4]), 12);
        for (int i = 0; i < 17; i++) begin
            trap(0, 32'h700, 32'h800);
            step();
        end
        chk("t5_tc0_wrap", longint'(trap_count[3:0]), 1);
        chk("t5_drop_hold", longint'(drop_count), 15);

        // enable=0 ignores traps, then reset while partly full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            trap(0, 32'h900 + 32'(i), 32'hA00);
            step();
        end
        chk("t6_level", longint'(level), 5);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trap(0, 32'hBAD, 32'hBAD); trap(1, 32'hBAD, 32'hBAD);
            step();
        end
        chk("t6_dis_level", longint'(level), 5);
        chk("t6_dis_tc", longint'(trap_count), 'h05);
        chk("t6_dis_drop", longint'(drop_count), 0);
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b0;
        enable    = 1'b1;
        chk("t6_rst_level", longint'(level), 0);
        chk("t6_rst_valid", longint'(out_valid), 0);
        chk("t6_rst_tc", longint'(trap_count), 0);
        chk("t6_rst_drop", longint'(drop_count), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
